// File: rtl/iob_pcie_chnl_pkg.sv
// Shared types and helpers for the iob_pcie channel sequencer:
// RX/TX state encodings and the word-length to 64-bit-beat conversion.
package iob_pcie_chnl_pkg;

    localparam int unsigned WORDS_PER_BEAT = 2;
    localparam logic [63:0] OFF_ZERO       = '0;

    typedef enum logic [2:0] {
        R_IDLE,
        R_ACK,
        R_DATA,
        R_WAIT,
        R_DONE
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_REQ,
        T_DATA,
        T_DONE
    } tx_state_t;

    // Caller zero-extends the length, so an all-ones length rounds up without wrapping.
    function automatic logic [63:0] beats_from_len(input logic [63:0] len);
        return (len + 64'(WORDS_PER_BEAT - 1)) / 64'(WORDS_PER_BEAT);
    endfunction

endpackage

// File: rtl/iob_pcie_beat_cnt.sv
// Beat counter: load clears the count and captures the target, inc advances it;
// done flags count==target, near flags that the next increment reaches the target.
module iob_pcie_beat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] target,
    input  logic         inc,
    output logic         done,
    output logic         near
);

    logic [W-1:0] count;
    logic [W-1:0] goal;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
            goal  <= '0;
        end else if (load) begin
            count <= '0;
            goal  <= target;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == goal);
    assign near = ((count + W'(1)) == goal);

endmodule

// File: rtl/iob_pcie_chnl_ctrl.sv
// RIFFA-style PCIe channel sequencer: independent RX and TX handshake FSMs
// that count 64-bit beats and gate the RX/TX FIFO strobes.
module iob_pcie_chnl_ctrl
    import iob_pcie_chnl_pkg::*;
#(
    parameter int unsigned C_PCI_DATA_WIDTH = 64,
    parameter int unsigned LEN_W            = 32,
    parameter int unsigned ACK_TO           = 1024
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        chnl_rx_i,
    input  logic                        chnl_rx_last_i,
    input  logic                        chnl_rx_data_valid_i,
    input  logic [LEN_W-1:0]            chnl_rx_len_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] chnl_rx_data_i,
    output logic                        chnl_rx_ack_o,
    output logic                        chnl_rx_data_ren_o,
    input  logic                        rxf_full_i,
    output logic                        rxf_wr_o,
    output logic [C_PCI_DATA_WIDTH-1:0] rxf_wdata_o,
    output logic                        rx_done_o,
    output logic                        rx_err_o,
    output logic [LEN_W-1:0]            rx_len_o,
    input  logic                        tx_start_i,
    input  logic [LEN_W-1:0]            tx_len_i,
    input  logic                        txf_empty_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] txf_rdata_i,
    output logic                        txf_ren_o,
    output logic                        chnl_tx_o,
    output logic                        chnl_tx_last_o,
    output logic                        chnl_tx_data_valid_o,
    output logic [LEN_W-1:0]            chnl_tx_len_o,
    output logic [LEN_W-2:0]            chnl_tx_off_o,
    output logic [C_PCI_DATA_WIDTH-1:0] chnl_tx_data_o,
    input  logic                        chnl_tx_data_ren_i,
    input  logic                        chnl_tx_ack_i,
    output logic                        tx_busy_o,
    output logic                        tx_done_o,
    output logic                        tx_err_o
);

    localparam int unsigned TO_W = $clog2(ACK_TO + 1);

    // RX LAST carries no information the beat count does not already give.
    logic unused_rx_last;
    assign unused_rx_last = chnl_rx_last_i;

    assign rxf_wdata_o    = chnl_rx_data_i;
    assign chnl_tx_data_o = txf_rdata_i;
    assign chnl_tx_last_o = 1'b1;
    assign chnl_tx_off_o  = (LEN_W-1)'(OFF_ZERO);

    // ---------------- RX ----------------
    rx_state_t        rx_state, rx_next;
    logic             rx_load, rx_trunc;
    logic             rx_cnt_done, rx_cnt_near;
    logic [LEN_W-1:0] rx_beats;

    assign rx_beats = LEN_W'(beats_from_len(64'(chnl_rx_len_i)));

    iob_pcie_beat_cnt #(.W(LEN_W)) u_rx_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (rx_load),
        .target (rx_beats),
        .inc    (rxf_wr_o),
        .done   (rx_cnt_done),
        .near   (rx_cnt_near)
    );

    always_comb begin
        rx_next            = rx_state;
        rx_load            = 1'b0;
        rx_trunc           = 1'b0;
        chnl_rx_data_ren_o = 1'b0;
        rxf_wr_o           = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (chnl_rx_i) begin
                    rx_next = R_ACK;
                    rx_load = 1'b1;
                end
            end
            R_ACK:  rx_next = rx_cnt_done ? R_WAIT : R_DATA;
            R_DATA: begin
                chnl_rx_data_ren_o = ~rxf_full_i;
                rxf_wr_o           = chnl_rx_data_ren_o & chnl_rx_data_valid_i;
                if (rxf_wr_o && rx_cnt_near) begin
                    rx_next = R_WAIT;
                end else if (!chnl_rx_i) begin
                    rx_next  = R_DONE;
                    rx_trunc = 1'b1;
                end
            end
            R_WAIT: if (!chnl_rx_i) rx_next = R_DONE;
            R_DONE: rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_state      <= R_IDLE;
            chnl_rx_ack_o <= 1'b0;
            rx_done_o     <= 1'b0;
            rx_err_o      <= 1'b0;
            rx_len_o      <= '0;
        end else begin
            rx_state      <= rx_next;
            chnl_rx_ack_o <= (rx_next == R_ACK);
            rx_done_o     <= (rx_next == R_DONE);
            rx_err_o      <= rx_trunc;
            if (rx_load) rx_len_o <= chnl_rx_len_i;
        end
    end

    // ---------------- TX ----------------
    tx_state_t       tx_state, tx_next;
    logic            tx_load, tx_timeout;
    logic            tx_cnt_done, tx_cnt_near;
    logic [TO_W-1:0] to_cnt;

    iob_pcie_beat_cnt #(.W(LEN_W)) u_tx_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (tx_load),
        .target (LEN_W'(beats_from_len(64'(tx_len_i)))),
        .inc    (txf_ren_o),
        .done   (tx_cnt_done),
        .near   (tx_cnt_near)
    );

    always_comb begin
        tx_next              = tx_state;
        tx_load              = 1'b0;
        tx_timeout           = 1'b0;
        chnl_tx_data_valid_o = 1'b0;
        txf_ren_o            = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (tx_start_i) begin
                    tx_next = T_REQ;
                    tx_load = 1'b1;
                end
            end
            T_REQ: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (chnl_tx_ack_i) begin
                    tx_next = tx_cnt_done ? T_DONE : T_DATA;
                end else if (to_cnt == TO_W'(ACK_TO - 1)) begin
                    tx_next    = T_IDLE;
                    tx_timeout = 1'b1;
                end
            end
            T_DATA: begin
                chnl_tx_data_valid_o = ~txf_empty_i;
                txf_ren_o            = chnl_tx_data_valid_o & chnl_tx_data_ren_i;
                if (txf_ren_o && tx_cnt_near) tx_next = T_DONE;
            end
            T_DONE:  tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tx_state      <= T_IDLE;
            to_cnt        <= '0;
            chnl_tx_o     <= 1'b0;
            chnl_tx_len_o <= '0;
            tx_busy_o     <= 1'b0;
            tx_done_o     <= 1'b0;
            tx_err_o      <= 1'b0;
        end else begin
            tx_state      <= tx_next;
            to_cnt        <= (tx_state == T_REQ) ? to_cnt + TO_W'(1) : '0;
            chnl_tx_o     <= (tx_next == T_REQ) || (tx_next == T_DATA);
            tx_busy_o     <= (tx_next != T_IDLE);
            tx_done_o     <= (tx_next == T_DONE);
            tx_err_o      <= tx_timeout;
            if (tx_load) chnl_tx_len_o <= tx_len_i;
        end
    end

endmodule
